seq_mult_arbiter: RTL and testbench
===================================

# seq_mult_arbiter

Shares one `seq_mult_adder` instance between `NREQ` requesters. Each request carries K-element row and column operands, an accumulator input and a per-request `bitSize`. The block arbitrates requests round-robin and captures the winner's operands. It then drives one transaction through the multiplier's valid/ready handshake and routes the 32-bit result back to the owning requester. It sits between the compute clients and the precision-scalable multiplier, and guarantees `bitSize` stays stable for the whole multiplier operation.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `K`, 2: dot-product length per request.
- `P`, 2: bits processed per multiplier step; operand width = `P*bitSize`.
- `MAX_WIDTH`, 16: operand container width.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_valid_i`  in  [NREQ]  request valid.
- `req_ready_o`  out  [NREQ]  request accepted (one-hot or zero).
- `req_row_i`, `req_col_i`  in  [NREQ][K] x MAX_WIDTH  signed operands.
- `req_c_i`  in  [NREQ] x 32  signed accumulator input.
- `req_bitsize_i`  in  [NREQ] x 5  precision code.
- `rsp_valid_o`  out  [NREQ]  response valid, one-hot or zero.
- `rsp_ready_i`  in  [NREQ]  response ready.
- `rsp_d_o`  out  32  result, shared by all requesters.
- `rsp_err_o`  out  1  invalid-bitsize error flag, qualified by `rsp_valid_o`.
- `mult_row_o`, `mult_col_o`, `mult_c_o`, `mult_bitsize_o`  out  operand widths  held operands to the multiplier.
- `mult_valid_o`  out  1  multiplier request valid.
- `mult_ready_i`  in  1  multiplier request ready.
- `mult_valid_i`  in  1  multiplier result valid.
- `mult_ready_o`  out  1  multiplier result ready.
- `mult_d_i`  in  32  multiplier result.
- `busy_o`  out  1  state != IDLE.
- `done_count_o`  out  32  completed responses; wraps modulo 2^32.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid_i` is set, the round-robin grant `g` is the first valid index at or after pointer `ptr`.
  - `req_ready_o[g]`=1 combinationally in that cycle only.
  - Operands, owner `g` and `bitsize` are registered.
  - Valid `bitsize` is 1..MAX_WIDTH/P. A valid request goes to ISSUE.
  - An invalid request (0 or >MAX_WIDTH/P) goes straight to RESP with err=1 and result=0. The multiplier is never touched.
- **ISSUE**: `mult_valid_o`=1; go to WAIT on `mult_ready_i`.
- **WAIT**: `mult_ready_o`=1; on `mult_valid_i`, register `mult_d_i` and go to RESP.
- **RESP**
  - `rsp_valid_o[owner]`=1; `rsp_d_o` and `rsp_err_o` come from registers.
  - On `rsp_ready_i[owner]`: go to IDLE, `ptr`=(owner+1) mod NREQ, and `done_count_o`++ (errors count too).
- `mult_*` operand outputs hold the registered values from the grant until the next grant. They never change in ISSUE or WAIT.
- Requests that arrive outside IDLE are not accepted. Requesters must hold valid and payload stable until ready.
- The arithmetic is the multiplier's. This block passes data unmodified and adds nothing.

## Timing
- Reset values:
  - state=IDLE, `ptr`=0, `done_count_o`=0.
  - All operand and result registers are 0.
  - `req_ready_o`, `rsp_valid_o`, `mult_valid_o`, `mult_ready_o`, `busy_o` and `rsp_err_o` are 0.
- Accept at cycle t puts `mult_valid_o`=1 at t+1.
- Minimum cycle, with the multiplier ready immediately and the result at the first WAIT cycle: ISSUE t+1, WAIT t+2, RESP t+3, IDLE t+4.
  - Next accept no earlier than t+4; at most one outstanding transaction.
- Error path: accept t, `rsp_valid_o` at t+1.
- Requests present in the same cycle: the lowest index at or after `ptr` wins. There is no starvation; a continuously requesting client waits at most NREQ-1 grants.
- Back-pressure: `rsp_ready_i`=0 holds RESP indefinitely and blocks every requester.
- Reset mid-operation:
  - Immediate return to reset values and any in-flight result is dropped.
  - The multiplier shares this reset (inverted onto its `rst_ni`).

## Structure
- Package `seq_mult_pkg` holds:
  - the state enum `seq_arb_state_e`;
  - constant `BITSIZE_W`=5;
  - a packed request struct `seq_mult_req_t` (row, col, c, bitsize).
- Sub-module `rr_arbiter`: combinational NREQ-way round-robin pick (inputs: valid vector, `ptr`; outputs: one-hot grant, index). `ptr` itself is registered in `seq_mult_arbiter`.

## Test plan
- **Single requester, valid bitsize:** req0 row={5,0}, col={-3,0}, c=0, bitsize=2.
  - Expect `mult_valid_o` the cycle after accept.
  - Expect `rsp_valid_o`=4'b0001, `rsp_d_o`=-15, err=0, `done_count_o`=1.
- **Four simultaneous requests after reset:** grants in order 0,1,2,3. Holding all valid repeats 0,1,2,3. Results route to the correct owners.
- **Invalid bitsize:** req2 with bitsize=0, then bitsize=9.
  - Each gives `rsp_valid_o`=4'b0100, err=1, `rsp_d_o`=0.
  - `mult_valid_o` never asserts; `done_count_o` increments.
- **Back-pressure:**
  - Hold `mult_ready_i`=0 for 5 cycles: `mult_valid_o` and operands stay stable.
  - Hold `rsp_ready_i`=0 for 10 cycles: `rsp_valid_o` and `rsp_d_o` stay stable, and no new `req_ready_o` asserts.
- **Reset in WAIT:** assert `rst_i` while in WAIT.
  - All outputs go to 0 asynchronously; no response is issued.
  - After release, the first request, from index 3, is granted with `ptr`=0 semantics.
- **Counter wrap:** preload/force `done_count_o`=32'hFFFF_FFFF, complete one request, expect 0.

Source files
------------

// File: rtl/seq_mult_arbiter_pkg.sv
// Shared types and helpers for the sequential multiplier arbiter slice.
package seq_mult_pkg;

    localparam int unsigned BITSIZE_W     = 5;
    localparam int unsigned SEQ_K         = 2;
    localparam int unsigned SEQ_MAX_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } seq_arb_state_e;

    // One captured request as handed to the multiplier.
    typedef struct packed {
        logic [SEQ_K-1:0][SEQ_MAX_WIDTH-1:0] row;
        logic [SEQ_K-1:0][SEQ_MAX_WIDTH-1:0] col;
        logic [31:0]                         c;
        logic [BITSIZE_W-1:0]                bitsize;
    } seq_mult_req_t;

    // A precision code is usable when it is 1..max_code.
    function automatic logic bitsize_ok(input logic [BITSIZE_W-1:0] bs,
                                        input int unsigned          max_code);
        return (bs != '0) && (32'(bs) <= max_code);
    endfunction

endpackage

// File: rtl/seq_mult_arbiter_if.sv
// Request/response and multiplier handshake bundle of the arbiter.
interface seq_mult_arbiter_if
    import seq_mult_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned K         = 2,
    parameter int unsigned MAX_WIDTH = 16
);

    // requester side
    logic [NREQ-1:0]                         req_valid_i;
    logic [NREQ-1:0]                         req_ready_o;
    logic [NREQ-1:0][K-1:0][MAX_WIDTH-1:0]   req_row_i;
    logic [NREQ-1:0][K-1:0][MAX_WIDTH-1:0]   req_col_i;
    logic [NREQ-1:0][31:0]                   req_c_i;
    logic [NREQ-1:0][BITSIZE_W-1:0]          req_bitsize_i;
    logic [NREQ-1:0]                         rsp_valid_o;
    logic [NREQ-1:0]                         rsp_ready_i;
    logic [31:0]                             rsp_d_o;
    logic                                    rsp_err_o;

    // multiplier side
    logic [K-1:0][MAX_WIDTH-1:0]             mult_row_o;
    logic [K-1:0][MAX_WIDTH-1:0]             mult_col_o;
    logic [31:0]                             mult_c_o;
    logic [BITSIZE_W-1:0]                    mult_bitsize_o;
    logic                                    mult_valid_o;
    logic                                    mult_ready_i;
    logic                                    mult_valid_i;
    logic                                    mult_ready_o;
    logic [31:0]                             mult_d_i;

    modport slave (
        input  req_valid_i, req_row_i, req_col_i, req_c_i, req_bitsize_i, rsp_ready_i,
        input  mult_ready_i, mult_valid_i, mult_d_i,
        output req_ready_o, rsp_valid_o, rsp_d_o, rsp_err_o,
        output mult_row_o, mult_col_o, mult_c_o, mult_bitsize_o, mult_valid_o, mult_ready_o
    );

    modport master (
        output req_valid_i, req_row_i, req_col_i, req_c_i, req_bitsize_i, rsp_ready_i,
        output mult_ready_i, mult_valid_i, mult_d_i,
        input  req_ready_o, rsp_valid_o, rsp_d_o, rsp_err_o,
        input  mult_row_o, mult_col_o, mult_c_o, mult_bitsize_o, mult_valid_o, mult_ready_o
    );

endinterface

// File: rtl/seq_mult_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid index at or after ptr.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_any
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // Walk the requesters starting at ptr, wrapping at NREQ, keep the first hit.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            sum = (IW+1)'(ptr) + (IW+1)'(i);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            cand = sum[IW-1:0];
            if (!grant_any && req_valid[cand]) begin
                grant_any   = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_mult_arbiter.sv
// Shares one sequential multiplier between NREQ requesters, one transaction at a time.
module seq_mult_arbiter
    import seq_mult_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned K         = 2,
    parameter int unsigned P         = 2,
    parameter int unsigned MAX_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    seq_mult_arbiter_if.slave      bus,
    output logic                   busy_o,
    output logic [31:0]            done_count_o
);

    localparam int unsigned IW       = $clog2(NREQ);
    localparam int unsigned MAX_CODE = MAX_WIDTH / P;

    // The captured-request struct has fixed field widths.
    if (K != SEQ_K || MAX_WIDTH != SEQ_MAX_WIDTH || NREQ < 2 || NREQ > 8) begin : g_param_check
        $error("seq_mult_arbiter: K/MAX_WIDTH must match seq_mult_pkg and NREQ must be 2..8");
    end

    seq_arb_state_e  state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   owner_q;
    seq_mult_req_t   req_q;
    logic [31:0]     result_q;
    logic            err_q;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            grant_any;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req_valid (bus.req_valid_i),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Accept and response strobes; accept is only offered in IDLE outside reset.
    always_comb begin
        bus.req_ready_o = '0;
        bus.rsp_valid_o = '0;
        if (state_q == IDLE && !rst_i) begin
            bus.req_ready_o = grant;
        end
        if (state_q == RESP) begin
            bus.rsp_valid_o[owner_q] = 1'b1;
        end
    end

    assign bus.mult_valid_o   = (state_q == ISSUE);
    assign bus.mult_ready_o   = (state_q == WAIT);
    assign busy_o             = (state_q != IDLE);
    assign bus.rsp_d_o        = result_q;
    assign bus.rsp_err_o      = err_q;
    assign bus.mult_row_o     = req_q.row;
    assign bus.mult_col_o     = req_q.col;
    assign bus.mult_c_o       = req_q.c;
    assign bus.mult_bitsize_o = req_q.bitsize;

    // Transaction FSM: capture winner, run multiplier handshake, return result to owner.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            req_q        <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
            done_count_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        owner_q       <= grant_idx;
                        req_q.row     <= bus.req_row_i[grant_idx];
                        req_q.col     <= bus.req_col_i[grant_idx];
                        req_q.c       <= bus.req_c_i[grant_idx];
                        req_q.bitsize <= bus.req_bitsize_i[grant_idx];
                        result_q      <= '0;
                        if (bitsize_ok(bus.req_bitsize_i[grant_idx], MAX_CODE)) begin
                            err_q   <= 1'b0;
                            state_q <= ISSUE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.mult_ready_i) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mult_valid_i) begin
                        result_q <= bus.mult_d_i;
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i[owner_q]) begin
                        state_q      <= IDLE;
                        ptr_q        <= (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
                        done_count_o <= done_count_o + 32'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_arbiter.sv
// Directed self-checking bench for seq_mult_arbiter with a behavioural multiplier stub.
module tb_seq_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [31:0] done_count;
    logic        hold_mult_ready  = 1'b0;
    logic        hold_mult_result = 1'b0;
    int          checks   = 0;
    int          errors   = 0;
    int          exp_done = 0;

    seq_mult_arbiter_if #(.NREQ(4), .K(2), .MAX_WIDTH(16)) bus ();

    seq_mult_arbiter #(
        .NREQ      (4),
        .K         (2),
        .P         (2),
        .MAX_WIDTH (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (bus.slave),
        .busy_o       (busy),
        .done_count_o (done_count)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: signed dot product plus accumulator.
    function automatic logic [31:0] stub_dot(input logic [1:0][15:0] r,
                                             input logic [1:0][15:0] k,
                                             input logic [31:0]      c);
        logic signed [31:0] acc;
        acc = $signed(c);
        for (int i = 0; i < 2; i++) begin
            acc = acc + 32'($signed(r[i])) * 32'($signed(k[i]));
        end
        return acc;
    endfunction

    assign bus.mult_ready_i = ~hold_mult_ready;
    assign bus.mult_valid_i = ~hold_mult_result;
    assign bus.mult_d_i     = stub_dot(bus.mult_row_o, bus.mult_col_o, bus.mult_c_o);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs;
        bus.req_valid_i   = '0;
        bus.req_row_i     = '0;
        bus.req_col_i     = '0;
        bus.req_c_i       = '0;
        bus.req_bitsize_i = '0;
        bus.rsp_ready_i   = '1;
    endtask

    task automatic set_req(input int idx, input int r0, input int r1, input int k0,
                           input int k1, input int c, input int bs);
        bus.req_row_i[idx][0]  = 16'(r0);
        bus.req_row_i[idx][1]  = 16'(r1);
        bus.req_col_i[idx][0]  = 16'(k0);
        bus.req_col_i[idx][1]  = 16'(k1);
        bus.req_c_i[idx]       = 32'(c);
        bus.req_bitsize_i[idx] = 5'(bs);
        bus.req_valid_i[idx]   = 1'b1;
    endtask

    task automatic wait_ready;
        for (int n = 0; n < 20; n++) begin
            if (bus.req_ready_o != '0) break;
            tick();
        end
    endtask

    task automatic wait_rsp;
        for (int n = 0; n < 20; n++) begin
            if (bus.rsp_valid_o != '0) break;
            tick();
        end
    endtask

    task automatic test_reset;
        clear_reqs();
        bus.req_valid_i = 4'b1111;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0h expected 0", busy); end
        checks++; if (bus.req_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %0h expected 0", bus.req_ready_o); end
        checks++; if (bus.rsp_valid_o !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %0h expected 0", bus.rsp_valid_o); end
        checks++; if (bus.mult_valid_o !== 1'b0) begin errors++; $display("FAIL reset_mult_valid: got %0h expected 0", bus.mult_valid_o); end
        checks++; if (bus.mult_ready_o !== 1'b0) begin errors++; $display("FAIL reset_mult_ready: got %0h expected 0", bus.mult_ready_o); end
        checks++; if (bus.rsp_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %0h expected 0", bus.rsp_err_o); end
        checks++; if (bus.rsp_d_o !== 32'h0) begin errors++; $display("FAIL reset_rsp_d: got %0h expected 0", bus.rsp_d_o); end
        checks++; if (done_count !== 32'h0) begin errors++; $display("FAIL reset_done: got %0h expected 0", done_count); end
        checks++; if (bus.mult_row_o !== 32'h0) begin errors++; $display("FAIL reset_mult_row: got %0h expected 0", bus.mult_row_o); end
        clear_reqs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single;
        set_req(0, 5, 0, -3, 0, 0, 2);
        #1;
        checks++; if (bus.req_ready_o !== 4'b0001) begin errors++; $display("FAIL single_accept: got %0h expected 1", bus.req_ready_o); end
        tick();
        bus.req_valid_i = '0;
        checks++; if (bus.mult_valid_o !== 1'b1) begin errors++; $display("FAIL single_mult_valid: got %0h expected 1", bus.mult_valid_o); end
        checks++; if (bus.mult_bitsize_o !== 5'd2) begin errors++; $display("FAIL single_bitsize: got %0h expected 2", bus.mult_bitsize_o); end
        tick();
        checks++; if (bus.mult_ready_o !== 1'b1 || bus.mult_valid_o !== 1'b0) begin errors++; $display("FAIL single_wait: got ready %0h valid %0h expected 1 0", bus.mult_ready_o, bus.mult_valid_o); end
        tick();
        checks++; if (bus.rsp_valid_o !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid: got %0h expected 1", bus.rsp_valid_o); end
        checks++; if (bus.rsp_d_o !== 32'hFFFF_FFF1) begin errors++; $display("FAIL single_rsp_d: got %0h expected fffffff1", bus.rsp_d_o); end
        checks++; if (bus.rsp_err_o !== 1'b0) begin errors++; $display("FAIL single_err: got %0h expected 0", bus.rsp_err_o); end
        tick();
        exp_done++;
        checks++; if (done_count !== 32'(exp_done) || busy !== 1'b0) begin errors++; $display("FAIL single_done: got %0h busy %0h expected %0h busy 0", done_count, busy, exp_done); end
    endtask

    task automatic test_round_robin;
        int exp_rr [4] = '{1, 14, 27, 40};
        logic [3:0] onehot;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_done = 0;
        for (int i = 0; i < 4; i++) begin
            set_req(i, i + 1, 2, 3, -1, 10 * i, 4);
        end
        #1;
        for (int g = 0; g < 8; g++) begin
            onehot = 4'b0001 << (g % 4);
            wait_ready();
            checks++; if (bus.req_ready_o !== onehot) begin errors++; $display("FAIL rr_grant%0d: got %0h expected %0h", g, bus.req_ready_o, onehot); end
            tick();
            wait_rsp();
            checks++; if (bus.rsp_valid_o !== onehot) begin errors++; $display("FAIL rr_owner%0d: got %0h expected %0h", g, bus.rsp_valid_o, onehot); end
            checks++; if (bus.rsp_d_o !== 32'(exp_rr[g % 4])) begin errors++; $display("FAIL rr_data%0d: got %0h expected %0h", g, bus.rsp_d_o, exp_rr[g % 4]); end
            tick();
            exp_done++;
            checks++; if (done_count !== 32'(exp_done)) begin errors++; $display("FAIL rr_done%0d: got %0h expected %0h", g, done_count, exp_done); end
        end
        clear_reqs();
        #1;
    endtask

    task automatic test_invalid_bitsize;
        int bad_bs [2] = '{0, 9};
        for (int b = 0; b < 2; b++) begin
            set_req(2, 1, 1, 1, 1, 5, bad_bs[b]);
            #1;
            checks++; if (bus.req_ready_o !== 4'b0100) begin errors++; $display("FAIL bad%0d_accept: got %0h expected 4", b, bus.req_ready_o); end
            tick();
            bus.req_valid_i = '0;
            checks++; if (bus.rsp_valid_o !== 4'b0100) begin errors++; $display("FAIL bad%0d_rsp_valid: got %0h expected 4", b, bus.rsp_valid_o); end
            checks++; if (bus.rsp_err_o !== 1'b1) begin errors++; $display("FAIL bad%0d_err: got %0h expected 1", b, bus.rsp_err_o); end
            checks++; if (bus.rsp_d_o !== 32'h0) begin errors++; $display("FAIL bad%0d_rsp_d: got %0h expected 0", b, bus.rsp_d_o); end
            checks++; if (bus.mult_valid_o !== 1'b0) begin errors++; $display("FAIL bad%0d_mult_valid: got %0h expected 0", b, bus.mult_valid_o); end
            tick();
            exp_done++;
            checks++; if (done_count !== 32'(exp_done) || bus.mult_valid_o !== 1'b0) begin errors++; $display("FAIL bad%0d_done: got %0h mv %0h expected %0h mv 0", b, done_count, bus.mult_valid_o, exp_done); end
        end
        // Largest legal code (MAX_WIDTH/P = 8) takes the multiplier path.
        set_req(2, 1, 1, 1, 1, 5, 8);
        #1;
        checks++; if (bus.req_ready_o !== 4'b0100) begin errors++; $display("FAIL max_bs_accept: got %0h expected 4", bus.req_ready_o); end
        tick();
        bus.req_valid_i = '0;
        checks++; if (bus.mult_valid_o !== 1'b1) begin errors++; $display("FAIL max_bs_mult_valid: got %0h expected 1", bus.mult_valid_o); end
        tick();
        tick();
        checks++; if (bus.rsp_err_o !== 1'b0 || bus.rsp_d_o !== 32'd7) begin errors++; $display("FAIL max_bs_rsp: got err %0h d %0h expected err 0 d 7", bus.rsp_err_o, bus.rsp_d_o); end
        tick();
        exp_done++;
    endtask

    task automatic test_back_pressure;
        hold_mult_ready = 1'b1;
        set_req(1, 7, -2, 4, 6, 100, 3);
        #1;
        checks++; if (bus.req_ready_o !== 4'b0010) begin errors++; $display("FAIL bp_accept: got %0h expected 2", bus.req_ready_o); end
        tick();
        bus.req_valid_i[1]   = 1'b0;
        bus.req_row_i[1]     = '1;
        bus.req_bitsize_i[1] = '0;
        for (int n = 0; n < 5; n++) begin
            #1;
            checks++; if (bus.mult_valid_o !== 1'b1) begin errors++; $display("FAIL bp_mult_valid%0d: got %0h expected 1", n, bus.mult_valid_o); end
            checks++; if (bus.mult_row_o !== 32'hFFFE_0007 || bus.mult_col_o !== 32'h0006_0004) begin errors++; $display("FAIL bp_operands%0d: got %0h %0h expected fffe0007 60004", n, bus.mult_row_o, bus.mult_col_o); end
            checks++; if (bus.mult_c_o !== 32'd100 || bus.mult_bitsize_o !== 5'd3) begin errors++; $display("FAIL bp_c_bs%0d: got %0h %0h expected 64 3", n, bus.mult_c_o, bus.mult_bitsize_o); end
            tick();
        end
        hold_mult_ready = 1'b0;
        bus.rsp_ready_i = '0;
        set_req(0, 2, 3, 5, 5, -1, 4);
        tick();
        tick();
        for (int n = 0; n < 10; n++) begin
            checks++; if (bus.rsp_valid_o !== 4'b0010 || bus.rsp_d_o !== 32'd116) begin errors++; $display("FAIL bp_rsp_hold%0d: got %0h d %0h expected 2 d 74", n, bus.rsp_valid_o, bus.rsp_d_o); end
            checks++; if (bus.req_ready_o !== 4'b0000) begin errors++; $display("FAIL bp_no_accept%0d: got %0h expected 0", n, bus.req_ready_o); end
            tick();
        end
        bus.rsp_ready_i = '1;
        tick();
        exp_done++;
        checks++; if (done_count !== 32'(exp_done)) begin errors++; $display("FAIL bp_done: got %0h expected %0h", done_count, exp_done); end
        checks++; if (bus.req_ready_o !== 4'b0001) begin errors++; $display("FAIL bp_next_accept: got %0h expected 1", bus.req_ready_o); end
        tick();
        bus.req_valid_i = '0;
        tick();
        tick();
        checks++; if (bus.rsp_valid_o !== 4'b0001 || bus.rsp_d_o !== 32'd24) begin errors++; $display("FAIL bp_next_rsp: got %0h d %0h expected 1 d 18", bus.rsp_valid_o, bus.rsp_d_o); end
        tick();
        exp_done++;
    endtask

    task automatic test_reset_in_wait;
        hold_mult_result = 1'b1;
        set_req(3, -4, 0, -4, 0, 0, 2);
        #1;
        checks++; if (bus.req_ready_o !== 4'b1000) begin errors++; $display("FAIL rw_accept: got %0h expected 8", bus.req_ready_o); end
        tick();
        bus.req_valid_i = '0;
        tick();
        checks++; if (bus.mult_ready_o !== 1'b1) begin errors++; $display("FAIL rw_in_wait: got %0h expected 1", bus.mult_ready_o); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || bus.mult_ready_o !== 1'b0 || bus.mult_valid_o !== 1'b0) begin errors++; $display("FAIL rw_async_ctrl: got busy %0h mr %0h mv %0h expected 0 0 0", busy, bus.mult_ready_o, bus.mult_valid_o); end
        checks++; if (bus.rsp_valid_o !== 4'b0000 || done_count !== 32'h0) begin errors++; $display("FAIL rw_async_rsp: got %0h done %0h expected 0 0", bus.rsp_valid_o, done_count); end
        checks++; if (bus.mult_row_o !== 32'h0 || bus.rsp_d_o !== 32'h0) begin errors++; $display("FAIL rw_async_data: got %0h %0h expected 0 0", bus.mult_row_o, bus.rsp_d_o); end
        exp_done = 0;
        tick();
        hold_mult_result = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.rsp_valid_o !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rw_no_rsp: got %0h busy %0h expected 0 0", bus.rsp_valid_o, busy); end
        set_req(3, 3, 3, -2, -2, 7, 2);
        #1;
        checks++; if (bus.req_ready_o !== 4'b1000) begin errors++; $display("FAIL rw_regrant: got %0h expected 8", bus.req_ready_o); end
        tick();
        bus.req_valid_i = '0;
        tick();
        tick();
        checks++; if (bus.rsp_valid_o !== 4'b1000 || bus.rsp_d_o !== 32'hFFFF_FFFB) begin errors++; $display("FAIL rw_rsp: got %0h d %0h expected 8 d fffffffb", bus.rsp_valid_o, bus.rsp_d_o); end
        tick();
        exp_done++;
        checks++; if (done_count !== 32'(exp_done)) begin errors++; $display("FAIL rw_done: got %0h expected %0h", done_count, exp_done); end
    endtask

    task automatic test_counter_wrap;
        force dut.done_count_o = 32'hFFFF_FFFF;
        #1;
        release dut.done_count_o;
        #1;
        set_req(0, 1, 0, 1, 0, 0, 1);
        #1;
        checks++; if (bus.req_ready_o !== 4'b0001) begin errors++; $display("FAIL wrap_accept: got %0h expected 1", bus.req_ready_o); end
        tick();
        bus.req_valid_i = '0;
        tick();
        tick();
        checks++; if (bus.rsp_d_o !== 32'd1) begin errors++; $display("FAIL wrap_rsp_d: got %0h expected 1", bus.rsp_d_o); end
        tick();
        checks++; if (done_count !== 32'h0) begin errors++; $display("FAIL wrap_done: got %0h expected 0", done_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_invalid_bitsize();
        test_back_pressure();
        test_reset_in_wait();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
